// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the trap source: cause codes, FSM states and the
// cause priority encoder.
package int_ctrl_pkg;

  // Cause codes as seen by NPC on int_pend.
  localparam logic [2:0] INT_NONE          = 3'd0;
  localparam logic [2:0] INT_ILLEGAL_INSTR = 3'd1;
  localparam logic [2:0] INT_ECALL         = 3'd2;
  localparam logic [2:0] INT_BUTTOM        = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_HANDLER = 2'd2
  } state_t;

  // Fixed priority: illegal > ecall > button. One cause per trap.
  function automatic logic [2:0] pick_cause(input logic illegal, input logic ecall,
                                            input logic btn);
    if (illegal)    return INT_ILLEGAL_INSTR;
    else if (ecall) return INT_ECALL;
    else if (btn)   return INT_BUTTOM;
    else            return INT_NONE;
  endfunction

endpackage

// File: rtl/int_ctrl_btn_debounce.sv
// Push-button conditioning: 2-FF synchronizer, stability counter and a
// rising-edge pulse of the debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;
  logic             at_tc;

  assign at_tc = (cnt == TC);

  // Synchronize, then accept a new level only after it has been stable for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the old level restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (at_tc) begin
        cnt   <= '0;
        level <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // High in the cycle whose edge raises the debounced level, so the pending
  // flag in the parent is set on that same edge.
  assign rise = sync2 & ~level & at_tc;

endmodule

// File: rtl/int_ctrl.sv
// Trap request source for NPC: arbitrates illegal/ecall/button causes,
// handshakes with the pipeline stall and tracks the exception level.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int CNT_W           = 17
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_raw,
  input  logic       illegal_ex,
  input  logic       ecall_ex,
  input  logic       sret_ex,
  input  logic       pc_write,
  output logic       int_signal,
  output logic [2:0] int_pend,
  output logic       exl_set,
  output logic       int_taken,
  output logic       nested_err
);

  state_t     state;
  logic [2:0] req_code;
  logic       btn_pending;
  logic       btn_rise;
  logic [2:0] cause;
  logic       btn_take;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_btn_debounce (
    .clk    (clk),
    .rst    (rst),
    .btn_raw(btn_raw),
    .rise   (btn_rise)
  );

  assign cause    = pick_cause(illegal_ex, ecall_ex, btn_pending);
  assign btn_take = int_taken && (int_pend == INT_BUTTOM);

  // Mealy request path: in IDLE the trap must be raised while PC_EX is still
  // the faulting PC. Gated by rst so nothing leaks out during reset.
  always_comb begin
    int_signal = 1'b0;
    int_pend   = INT_NONE;
    int_taken  = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE: begin
          if (cause != INT_NONE) begin
            int_signal = 1'b1;
            int_pend   = cause;
            int_taken  = pc_write;
          end
        end
        ST_REQ: begin
          int_signal = 1'b1;
          int_pend   = req_code;
          int_taken  = pc_write;
        end
        default: ;
      endcase
    end
  end

  // Handshake FSM, exception level, sticky nested error and button queue.
  // A new button edge wins over the clear so a second press stays queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      req_code    <= INT_NONE;
      exl_set     <= 1'b0;
      nested_err  <= 1'b0;
      btn_pending <= 1'b0;
    end else begin
      if (btn_rise)      btn_pending <= 1'b1;
      else if (btn_take) btn_pending <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (cause != INT_NONE) begin
            if (pc_write) begin
              state   <= ST_HANDLER;
              exl_set <= 1'b1;
            end else begin
              req_code <= cause;
              state    <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (pc_write) begin
            state   <= ST_HANDLER;
            exl_set <= 1'b1;
          end
        end
        ST_HANDLER: begin
          if (illegal_ex || ecall_ex) nested_err <= 1'b1;
          if (sret_ex && pc_write) begin
            state   <= ST_IDLE;
            exl_set <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl with a small debounce window. Accepted traps
// are checked by a monitor against a queue of expected causes.
module tb_int_ctrl;
  import int_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst, btn_raw, illegal_ex, ecall_ex, sret_ex, pc_write;
  logic       int_signal, exl_set, int_taken, nested_err;
  logic [2:0] int_pend;

  int total = 0;
  int bad   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp_code;

  int_ctrl #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .illegal_ex(illegal_ex),
    .ecall_ex(ecall_ex), .sret_ex(sret_ex), .pc_write(pc_write),
    .int_signal(int_signal), .int_pend(int_pend), .exl_set(exl_set),
    .int_taken(int_taken), .nested_err(nested_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string nm);
    chk({nm, ".int_signal"}, int'(int_signal), 0);
    chk({nm, ".int_pend"},   int'(int_pend),   0);
    chk({nm, ".exl_set"},    int'(exl_set),    0);
    chk({nm, ".int_taken"},  int'(int_taken),  0);
    chk({nm, ".nested_err"}, int'(nested_err), 0);
  endtask

  // Monitor: every accepted trap must match the next expected cause.
  always @(negedge clk) begin
    if (int_taken === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_trap: got cause %0d expected no trap (t=%0t)", int_pend, $time);
      end else begin
        exp_code = exp_q.pop_front();
        chk("trap_cause", int'(int_pend), int'(exp_code));
        chk("trap_signal", int'(int_signal), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    // 1: reset with every input high, then release with inputs low
    rst = 1; btn_raw = 1; illegal_ex = 1; ecall_ex = 1; sret_ex = 1; pc_write = 1;
    step(); step(); #2;
    all_zero("rst_hold");
    step();
    rst = 0; btn_raw = 0; illegal_ex = 0; ecall_ex = 0; sret_ex = 0; pc_write = 0;
    #2 all_zero("rst_release");
    for (int i = 0; i < 3; i++) begin
      step(); #2;
      chk("idle_quiet.int_signal", int'(int_signal), 0);
      chk("idle_quiet.exl_set", int'(exl_set), 0);
    end

    // 2: ecall accepted immediately
    step(); ecall_ex = 1; pc_write = 1; exp_q.push_back(INT_ECALL);
    #2;
    chk("ecall.int_signal", int'(int_signal), 1);
    chk("ecall.int_pend", int'(int_pend), int'(INT_ECALL));
    chk("ecall.int_taken", int'(int_taken), 1);
    step(); ecall_ex = 0; #2;
    chk("ecall.exl_set", int'(exl_set), 1);
    chk("ecall.handler_signal", int'(int_signal), 0);
    chk("ecall.handler_taken", int'(int_taken), 0);
    step(); sret_ex = 1; #2;
    chk("ecall.exl_during_sret", int'(exl_set), 1);
    step(); sret_ex = 0; #2;
    chk("ecall.exl_after_sret", int'(exl_set), 0);

    // 3: illegal and ecall together under a 3-cycle stall
    for (int i = 0; i < 3; i++) begin
      step(); illegal_ex = 1; ecall_ex = 1; pc_write = 0; #2;
      chk("stall.int_signal", int'(int_signal), 1);
      chk("stall.int_pend", int'(int_pend), int'(INT_ILLEGAL_INSTR));
      chk("stall.int_taken", int'(int_taken), 0);
    end
    step(); pc_write = 1; exp_q.push_back(INT_ILLEGAL_INSTR); #2;
    chk("stall.release_taken", int'(int_taken), 1);
    step(); illegal_ex = 0; ecall_ex = 0; #2;
    chk("stall.exl_set", int'(exl_set), 1);
    chk("stall.taken_once", int'(int_taken), 0);
    step(); sret_ex = 1; step(); sret_ex = 0; #2;
    chk("stall.exl_cleared", int'(exl_set), 0);

    // 4a: 3-cycle glitch must not trap
    step(); btn_raw = 1;
    for (int k = 1; k <= 12; k++) begin
      step(); btn_raw = (k < 3); #2;
      chk("glitch.int_signal", int'(int_signal), 0);
    end

    // 4b: 10-cycle press: trap raised 6 edges after the press, exactly once
    step(); btn_raw = 1;
    for (int k = 1; k <= 24; k++) begin
      step(); btn_raw = (k < 10); sret_ex = (k == 13); #2;
      chk("press.int_signal", int'(int_signal), (k == 6) ? 1 : 0);
      chk("press.exl_set", int'(exl_set), (k >= 7 && k <= 13) ? 1 : 0);
      if (k == 6) begin
        chk("press.int_pend", int'(int_pend), int'(INT_BUTTOM));
        exp_q.push_back(INT_BUTTOM);
      end
    end
    sret_ex = 0;

    // 5: button pressed inside a handler is taken right after return
    step(); ecall_ex = 1; exp_q.push_back(INT_ECALL);
    for (int k = 1; k <= 16; k++) begin
      step(); ecall_ex = 0; btn_raw = (k <= 8); #2;
      chk("hdl_btn.int_signal", int'(int_signal), 0);
      chk("hdl_btn.exl_set", int'(exl_set), 1);
    end
    step(); sret_ex = 1; #2;
    chk("hdl_btn.sret_cycle_signal", int'(int_signal), 0);
    step(); sret_ex = 0; exp_q.push_back(INT_BUTTOM); #2;
    chk("hdl_btn.after_ret_exl", int'(exl_set), 0);
    chk("hdl_btn.after_ret_signal", int'(int_signal), 1);
    chk("hdl_btn.after_ret_pend", int'(int_pend), int'(INT_BUTTOM));
    step(); #2;
    chk("hdl_btn.exl_set", int'(exl_set), 1);

    // 6: ecall inside the handler is dropped and sets the sticky error
    step(); ecall_ex = 1; #2;
    chk("nested.signal", int'(int_signal), 0);
    chk("nested.err_before", int'(nested_err), 0);
    step(); ecall_ex = 0; #2;
    chk("nested.err_set", int'(nested_err), 1);
    step(); sret_ex = 1;
    step(); sret_ex = 0; #2;
    chk("nested.idle_signal", int'(int_signal), 0);
    chk("nested.err_sticky", int'(nested_err), 1);
    step(); illegal_ex = 1; pc_write = 0; #2;
    chk("nested.req_enter", int'(int_signal), 1);
    step(); illegal_ex = 0; #2;
    chk("nested.req_hold_signal", int'(int_signal), 1);
    chk("nested.req_hold_pend", int'(int_pend), int'(INT_ILLEGAL_INSTR));
    step(); rst = 1; #2;
    chk("nested.rst_signal", int'(int_signal), 0);
    step(); rst = 0; #2;
    all_zero("req_reset");
    step(); pc_write = 1; #2;
    chk("req_reset.no_trap", int'(int_signal), 0);
    step(); #2;

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
